dds_freq_meter: RTL and testbench
=================================

DDS_FREQ_METER -- requirements
Module: dds_freq_meter

Interface
REQ-001 Parameter HYST, default 8: hysteresis threshold magnitude in LSB, range 1..127.
REQ-002 Parameter NPER, default 4: periods averaged per result, power of two, range 1..256.
REQ-003 Parameter TIMEOUT, default 16_777_216: cycles without a rising crossing before abort, range 2..2^32-1.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 data_i  input  8  signed two's-complement sample stream, e.g. dds_generator data_o.
REQ-007 meas_en_i  input  1  measurement enable, level-sensitive.
REQ-008 period_o  output  32  averaged period in clk_i cycles, held between results.
REQ-009 valid_o  output  1  one-cycle pulse when period_o updates.
REQ-010 timeout_o  output  1  one-cycle pulse when no crossing occurs within TIMEOUT cycles.

Function
REQ-011 data_i SHALL be registered into sample register s every cycle; 1-cycle input latency.
REQ-012 Schmitt state h SHALL set when s >= +HYST and clear when s <= -HYST; otherwise h holds; exact ±HYST counts as crossing.
REQ-013 A rising event SHALL be the cycle h changes 0->1; falling transitions produce no event.
REQ-014 FSM states SHALL be IDLE, ARM, MEAS.
REQ-015 IDLE: entered while meas_en_i=0; cycle counter and edge counter cleared; period_o holds.
REQ-016 IDLE->ARM when meas_en_i=1; ARM->MEAS on first rising event, cycle counter loaded 1, edge counter 0.
REQ-017 In MEAS the cycle counter SHALL increment every cycle; each rising event increments the edge counter.
REQ-018 On the NPER-th rising event in MEAS: period_o = (cycle counter value at that cycle) >> log2(NPER), valid_o=1 next cycle, counters restart (cycle counter 1, edge counter 0), FSM stays MEAS (continuous measurement).
REQ-019 valid_o SHALL assert exactly 2 cycles after the clk_i edge that samples the data_i value completing the NPER-th crossing.
REQ-020 Cycle counter SHALL be 32 bits plus log2(NPER) guard bits; truncation of the shifted result to 32 bits SHALL not occur for legal TIMEOUT*NPER.
REQ-021 Timeout: in ARM or MEAS, if cycles since last rising event (or since entering ARM) reach TIMEOUT, timeout_o pulses one cycle, FSM -> ARM, counters cleared, period_o holds.
REQ-022 Rising event and timeout in same cycle: event wins, no timeout_o.
REQ-023 meas_en_i deasserted in any state: next state IDLE; in-flight measurement discarded, no valid_o or timeout_o.
REQ-024 valid_o and timeout_o SHALL never be high in the same cycle.

Reset
REQ-025 rst_i=1 SHALL immediately force: FSM IDLE, s=0, h=0, counters 0, period_o=0, valid_o=0, timeout_o=0.
REQ-026 Reset asserted mid-measurement SHALL discard partial results; after release the block re-arms from IDLE with no spurious pulses.
REQ-027 h SHALL reset to 0 so a positive first sample after reset yields a rising event.

Verification
REQ-028 Square wave +100/-100, 50 cycles each half, NPER=4, meas_en_i=1 -> valid_o every 400 cycles, period_o=100.
REQ-029 dds_generator (freq_i=4_294_967) output into data_i, NPER=4 -> period_o within 1000±1 on every valid_o.
REQ-030 data_i random in [-5,+5] with HYST=8, TIMEOUT=1000 -> no valid_o; timeout_o pulses every 1000 cycles after ARM entry.
REQ-031 Sample sequence exactly -8, +8 repeating every 20 cycles (10 each), NPER=1 -> period_o=20 (thresholds inclusive).
REQ-032 Drop meas_en_i after 2 of 4 edges, re-raise 10 cycles later -> no pulse during drop; next period_o correct, old value held meanwhile.
REQ-033 Assert rst_i asynchronously mid-MEAS -> all outputs 0 same cycle; after release, first valid_o only after NPER full periods.

Source files
------------

// File: rtl/dds_freq_meter.sv
// Measures the period of a signed sample stream: Schmitt-trigger rising crossings
// are timed over NPER periods and the cycle count is averaged by a right shift.
module dds_freq_meter #(
  parameter int              HYST    = 8,
  parameter int              NPER    = 4,
  parameter longint unsigned TIMEOUT = 64'd16_777_216
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic signed [7:0] data_i,
  input  logic              meas_en_i,
  output logic [31:0]       period_o,
  output logic              valid_o,
  output logic              timeout_o
);

  localparam int LG = $clog2(NPER);
  localparam int CW = 32 + LG;
  localparam int EW = LG + 1;
  localparam logic [EW-1:0]     EDGE_LAST = EW'(NPER - 1);
  localparam logic [31:0]       TO_LAST   = 32'(TIMEOUT - 1);
  localparam logic signed [7:0] TH_HI     = 8'(HYST);
  localparam logic signed [7:0] TH_LO     = 8'(-HYST);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  state_t            r_state, w_state_n;
  logic signed [7:0] r_s;
  logic              r_h, w_h_n;
  logic              r_rise;
  logic [CW-1:0]     r_cnt, w_cnt_n;
  logic [EW-1:0]     r_edges, w_edges_n;
  logic [31:0]       r_to, w_to_n;
  logic [31:0]       r_period, w_period_n;
  logic              r_valid, w_valid_n;
  logic              r_timeout, w_timeout_n;

  // Thresholds are inclusive; between them the trigger keeps its last state.
  always_comb begin
    w_h_n = r_h;
    if (r_s >= TH_HI)      w_h_n = 1'b1;
    else if (r_s <= TH_LO) w_h_n = 1'b0;
  end

  // The rising event is registered so the FSM acts one cycle after h changes,
  // giving valid_o two cycles after the sample that completes the crossing.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s    <= '0;
      r_h    <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_s    <= data_i;
      r_h    <= w_h_n;
      r_rise <= w_h_n & ~r_h;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_edges_n   = r_edges;
    w_to_n      = r_to;
    w_period_n  = r_period;
    w_valid_n   = 1'b0;
    w_timeout_n = 1'b0;
    if (!meas_en_i) begin
      w_state_n = IDLE;
      w_cnt_n   = '0;
      w_edges_n = '0;
      w_to_n    = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_n = ARM;
          w_cnt_n   = '0;
          w_edges_n = '0;
          w_to_n    = '0;
        end
        ARM: begin
          if (r_rise) begin
            w_state_n = MEAS;
            w_cnt_n   = CW'(1);
            w_edges_n = '0;
            w_to_n    = '0;
          end else if (r_to == TO_LAST) begin
            w_timeout_n = 1'b1;
            w_to_n      = '0;
          end else begin
            w_to_n = r_to + 32'd1;
          end
        end
        MEAS: begin
          if (r_rise) begin
            w_to_n = '0;
            if (r_edges == EDGE_LAST) begin
              w_period_n = 32'(r_cnt >> LG);
              w_valid_n  = 1'b1;
              w_cnt_n    = CW'(1);
              w_edges_n  = '0;
            end else begin
              w_cnt_n   = r_cnt + CW'(1);
              w_edges_n = r_edges + EW'(1);
            end
          end else if (r_to == TO_LAST) begin
            w_timeout_n = 1'b1;
            w_state_n   = ARM;
            w_cnt_n     = '0;
            w_edges_n   = '0;
            w_to_n      = '0;
          end else begin
            w_cnt_n = r_cnt + CW'(1);
            w_to_n  = r_to + 32'd1;
          end
        end
        default: w_state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_edges   <= '0;
      r_to      <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_edges   <= w_edges_n;
      r_to      <= w_to_n;
      r_period  <= w_period_n;
      r_valid   <= w_valid_n;
      r_timeout <= w_timeout_n;
    end
  end

  assign period_o  = r_period;
  assign valid_o   = r_valid;
  assign timeout_o = r_timeout;

endmodule

// File: tb/tb_dds_freq_meter.sv
// Directed bench for dds_freq_meter: table of square waves plus hand sequences
// for latency, timeout, enable drop and asynchronous reset.
module tb_dds_freq_meter;

  localparam int NPER = 4;
  localparam int TOUT = 1000;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              meas_en = 1'b0;
  logic signed [7:0] data_i;
  logic signed [7:0] gen_v;
  logic signed [7:0] man_v = '0;
  logic [31:0]       period_o, period1_o;
  logic              valid_o, timeout_o, valid1_o, timeout1_o;

  int                gen_mode = 0;
  int                wave_id  = 0;
  int                nh = 1, nl = 1;
  logic signed [7:0] hi_v = '0, lo_v = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int vcount  = 0;
  int tcount  = 0;
  int both_hi = 0;

  always #5 clk = ~clk;

  assign data_i = (gen_mode == 3) ? man_v : gen_v;

  dds_freq_meter #(.HYST(8), .NPER(NPER), .TIMEOUT(64'(TOUT))) u_dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .meas_en_i(meas_en),
    .period_o(period_o), .valid_o(valid_o), .timeout_o(timeout_o)
  );

  dds_freq_meter #(.HYST(8), .NPER(1), .TIMEOUT(64'(TOUT))) u_dut1 (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .meas_en_i(meas_en),
    .period_o(period1_o), .valid_o(valid1_o), .timeout_o(timeout1_o)
  );

  // Waveform source: restarts its phase whenever the main sequence bumps wave_id.
  initial begin
    int ph, seen, rv;
    gen_v = '0;
    ph    = 0;
    seen  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (wave_id != seen) begin
        seen = wave_id;
        ph   = 0;
      end
      if (gen_mode == 1) begin
        gen_v = (ph < nh) ? hi_v : lo_v;
        ph    = (ph + 1) % (nh + nl);
      end else if (gen_mode == 2) begin
        rv    = int'($urandom_range(10)) - 5;
        gen_v = 8'(rv);
      end else begin
        gen_v = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (valid_o) vcount++;
    if (timeout_o) tcount++;
    if (valid_o && timeout_o) both_hi++;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic set_wave(input logic signed [7:0] h, input logic signed [7:0] l,
                          input int a, input int b);
    hi_v = h; lo_v = l; nh = a; nl = b;
    wave_id++;
  endtask

  // which: 0 waits for valid_o, 1 for timeout_o; n counts negedges elapsed.
  task automatic wait_sig(input int which, input int budget, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      @(negedge clk);
      n++;
      if ((which == 0 && valid_o) || (which == 1 && timeout_o)) ok = 1'b1;
    end
  endtask

  typedef struct {
    logic signed [7:0] hi;
    logic signed [7:0] lo;
    int                nh;
    int                nl;
    logic [31:0]       exp;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int   n, per, p0, v0;
    bit   ok;

    tbl[0] = '{hi: 8'sd100, lo: -8'sd100, nh: 50, nl: 50, exp: 32'd100};
    tbl[1] = '{hi: 8'sd8,   lo: -8'sd8,   nh: 10, nl: 10, exp: 32'd20};
    tbl[2] = '{hi: 8'sd127, lo: -8'sd128, nh: 3,  nl: 5,  exp: 32'd8};
    tbl[3] = '{hi: 8'sd9,   lo: -8'sd9,   nh: 25, nl: 15, exp: 32'd40};
    tbl[4] = '{hi: 8'sd50,  lo: -8'sd20,  nh: 7,  nl: 7,  exp: 32'd14};

    for (int i = 0; i < 5; i++) begin
      meas_en  = 1'b0;
      gen_mode = 0;
      do_reset();
      chk("reset_state", {valid_o, timeout_o, period_o}, 0);
      per = tbl[i].nh + tbl[i].nl;
      set_wave(tbl[i].hi, tbl[i].lo, tbl[i].nh, tbl[i].nl);
      gen_mode = 1;
      meas_en  = 1'b1;
      wait_sig(0, (NPER + 2) * per + 20, n, ok);
      chk("first_valid_seen", ok, 1);
      chk("first_period", period_o, tbl[i].exp);
      wait_sig(0, NPER * per + 20, n, ok);
      chk("valid_spacing", n, NPER * per);
      chk("period", period_o, tbl[i].exp);
      chk("period_nper1", period1_o, tbl[i].exp);
    end

    // Exact latency: crossings 10 cycles apart, valid two cycles after the 5th sample.
    meas_en = 1'b0;
    do_reset();
    man_v    = -8'sd100;
    gen_mode = 3;
    meas_en  = 1'b1;
    repeat (5) @(negedge clk);
    for (int e = 0; e < 5; e++) begin
      man_v = 8'sd100;
      @(negedge clk);
      man_v = -8'sd100;
      if (e < 4) repeat (9) @(negedge clk);
    end
    chk("lat_e0", valid_o, 0);
    @(negedge clk);
    chk("lat_e1", valid_o, 0);
    @(negedge clk);
    chk("lat_e2_valid", valid_o, 1);
    chk("lat_period", period_o, 10);
    @(negedge clk);
    chk("lat_pulse_width", valid_o, 0);

    // Noise inside the hysteresis band: only timeouts, every TOUT cycles after ARM.
    meas_en  = 1'b0;
    gen_mode = 2;
    do_reset();
    repeat (2) @(negedge clk);
    v0      = vcount;
    meas_en = 1'b1;
    wait_sig(1, TOUT + 100, n, ok);
    chk("first_timeout_delay", n, TOUT + 1);
    wait_sig(1, TOUT + 100, n, ok);
    chk("timeout_spacing", n, TOUT);
    chk("noise_no_valid", vcount - v0, 0);

    // Enable drop mid-measurement, then re-raise on a faster wave.
    meas_en  = 1'b0;
    gen_mode = 0;
    do_reset();
    set_wave(8'sd100, -8'sd100, 50, 50);
    gen_mode = 1;
    meas_en  = 1'b1;
    wait_sig(0, 700, n, ok);
    chk("drop_pre_period", period_o, 100);
    repeat (200) @(negedge clk);
    p0      = vcount + tcount;
    meas_en = 1'b0;
    set_wave(8'sd100, -8'sd100, 30, 30);
    repeat (10) @(negedge clk);
    chk("drop_no_pulse", vcount + tcount - p0, 0);
    chk("drop_held", period_o, 100);
    meas_en = 1'b1;
    wait_sig(0, 6 * 60 + 40, n, ok);
    chk("drop_rearm_valid", ok, 1);
    chk("drop_new_period", period_o, 60);

    // Asynchronous reset mid-measurement.
    wait_sig(0, 300, n, ok);
    repeat (100) @(negedge clk);
    #2 rst_i = 1'b1;
    #1 chk("async_rst_outputs", {valid_o, timeout_o, period_o}, 0);
    @(negedge clk);
    rst_i = 1'b0;
    wait_sig(0, 700, n, ok);
    chk("rst_rearm_valid", ok, 1);
    chk("rst_rearm_full_periods", n >= NPER * 60, 1);
    chk("rst_rearm_period", period_o, 60);

    chk("valid_timeout_overlap", both_hi, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
